// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit, one result bit per cycle.
// Multiply uses shift-add over a 2*WORD accumulator; divide is restoring.
// Results land in HI/LO. Optional feature macro: MULDIV_SIGNED_EN compiles in
// signed MULT/DIV (op_i[1]=1). Without it, op_i[1] is ignored.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start_i; latches operands and op on start
// S_CALC | WORD iterations, down-counter from WORD-1 to 0
// S_FIX  | sign correction and divide-by-zero override, writes HI/LO
// S_DONE | done_o high for one cycle, then back to S_IDLE
module mul_div_unit #(
    parameter int WORD = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [WORD-1:0] a_i,
    input  logic [WORD-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [WORD-1:0] hi_o,
    output logic [WORD-1:0] lo_o,
    output logic            div_zero_o
);

    localparam int CNT_W = (WORD > 1) ? $clog2(WORD) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              is_div;
    logic              b_zero;
    logic [WORD-1:0]   a_lat;
    // Multiplicand for multiply, divisor for divide.
    logic [WORD-1:0]   opd;
    // Multiply: product high/low. Divide: partial remainder / shifting quotient.
    logic [WORD-1:0]   acc_hi;
    logic [WORD-1:0]   acc_lo;

    logic [WORD-1:0]   a_mag;
    logic [WORD-1:0]   b_mag;
    logic [WORD-1:0]   nxt_hi;
    logic [WORD-1:0]   nxt_lo;
    logic [WORD-1:0]   res_hi;
    logic [WORD-1:0]   res_lo;
    logic [WORD:0]     add_sum;
    logic [WORD:0]     trial;

`ifdef MULDIV_SIGNED_EN
    logic              sgn_sel;
    logic              neg_a;
    logic              neg_b;

    assign sgn_sel = op_i[1];
    assign a_mag   = (sgn_sel && a_i[WORD-1]) ? (~a_i + 1'b1) : a_i;
    assign b_mag   = (sgn_sel && b_i[WORD-1]) ? (~b_i + 1'b1) : b_i;
`else
    logic              unused_op_sign;

    assign unused_op_sign = op_i[1];
    assign a_mag          = a_i;
    assign b_mag          = b_i;
`endif

    assign busy_o = (state != S_IDLE);

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : {(WORD+1){1'b0}});
        trial   = {acc_hi, acc_lo[WORD-1]} - {1'b0, opd};
        nxt_hi  = acc_hi;
        nxt_lo  = acc_lo;
        if (is_div) begin
            if (!trial[WORD]) begin
                nxt_hi = trial[WORD-1:0];
                nxt_lo = {acc_lo[WORD-2:0], 1'b1};
            end else begin
                nxt_hi = {acc_hi[WORD-2:0], acc_lo[WORD-1]};
                nxt_lo = {acc_lo[WORD-2:0], 1'b0};
            end
        end else begin
            {nxt_hi, nxt_lo} = {add_sum, acc_lo[WORD-1:1]};
        end
    end

    // Final result: sign fix-up on magnitudes, then divide-by-zero override.
    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
`ifdef MULDIV_SIGNED_EN
        if (is_div) begin
            if (neg_a ^ neg_b) res_lo = ~acc_lo + 1'b1;
            if (neg_a)         res_hi = ~acc_hi + 1'b1;
        end else if (neg_a ^ neg_b) begin
            {res_hi, res_lo} = ~{acc_hi, acc_lo} + 1'b1;
        end
`endif
        if (is_div && b_zero) begin
            res_hi = a_lat;
            res_lo = '1;
        end
    end

    // Sequencing FSM with registered outputs and datapath registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_div     <= 1'b0;
            b_zero     <= 1'b0;
            a_lat      <= '0;
            opd        <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            done_o     <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            div_zero_o <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        is_div     <= op_i[0];
                        b_zero     <= (b_i == '0);
                        a_lat      <= a_i;
                        div_zero_o <= 1'b0;
                        cnt        <= CNT_W'(WORD - 1);
                        acc_hi     <= '0;
                        if (op_i[0]) begin
                            acc_lo <= a_mag;
                            opd    <= b_mag;
                        end else begin
                            acc_lo <= b_mag;
                            opd    <= a_mag;
                        end
`ifdef MULDIV_SIGNED_EN
                        neg_a      <= sgn_sel & a_i[WORD-1];
                        neg_b      <= sgn_sel & b_i[WORD-1];
`endif
                        state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    if (cnt == '0) begin
                        state <= S_FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    hi_o       <= res_hi;
                    lo_o       <= res_lo;
                    div_zero_o <= is_div & b_zero;
                    done_o     <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: arithmetic reference model plus cycle-phase
// tracking, checked every cycle, with directed literal cases and random ops.
module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    op_i = 2'b00;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;
    logic          div_zero_o;

    int total = 0;
    int bad   = 0;

    mul_div_unit #(.WORD(W)) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: returns {div_zero, hi, lo}.
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic   sgn;
        longint sa, sb, p, q, r;
        logic [63:0] up;
`ifdef MULDIV_SIGNED_EN
        sgn = op[1];
`else
        sgn = 1'b0;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[0]) begin
            if (sgn) begin
                p = sa * sb;
                return {1'b0, p[63:0]};
            end
            up = 64'(a) * 64'(b);
            return {1'b0, up};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
        end
        return {1'b0, a % b, a / b};
    endfunction

    // Model: phase counts cycles since the accepted start (0 = idle).
    int           phase = 0;
    logic [64:0]  pend = '0;
    logic [31:0]  exp_hi = '0;
    logic [31:0]  exp_lo = '0;
    logic         exp_dz = 1'b0;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            phase  = 0;
            exp_hi = '0;
            exp_lo = '0;
            exp_dz = 1'b0;
        end else if (phase == 0) begin
            if (start_i) begin
                pend   = ref_op(op_i, a_i, b_i);
                exp_dz = 1'b0;
                phase  = 1;
            end
        end else if (phase == W + 1) begin
            {exp_dz, exp_hi, exp_lo} = pend;
            phase = W + 2;
        end else if (phase == W + 2) begin
            phase = 0;
        end else begin
            phase = phase + 1;
        end
    end

    // Every-cycle compare against the model, away from the rising edge.
    always @(negedge clk_i) begin
        chk("mon_busy", 64'(busy_o), 64'(phase != 0));
        chk("mon_done", 64'(done_o), 64'(phase == W + 2));
        chk("mon_hi",   64'(hi_o),   64'(exp_hi));
        chk("mon_lo",   64'(lo_o),   64'(exp_lo));
        chk("mon_dz",   64'(div_zero_o), 64'(exp_dz));
    end

    // Issue one op; pulse: extra start pulses at cycles 5 and 34.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit pulse, output int lat, output logic dz1);
        int n;
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        n       = 0;
        lat     = -1;
        dz1     = 1'b1;
        while (n < 60) begin
            @(negedge clk_i);
            n++;
            if (n == 1) begin
                start_i = 1'b0;
                dz1     = div_zero_o;
                a_i     = $urandom;
                b_i     = $urandom;
            end
            if (pulse && n == 5) begin
                start_i = 1'b1;
                op_i    = 2'b01;
                a_i     = 32'd1000;
                b_i     = 32'd3;
            end
            if (pulse && n == 6) start_i = 1'b0;
            if (done_o) begin
                lat = n;
                if (pulse) begin
                    start_i = 1'b1;
                    op_i    = 2'b00;
                    a_i     = 32'd12345;
                    b_i     = 32'd678;
                end
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got none expected done within 60 cycles");
        end
        chk("latency", 64'(lat), 64'(W + 2));
        if (pulse) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    int   lat;
    logic dz1;

    initial begin
        #1 rstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_dz",   64'(div_zero_o), 64'd0);
        rstn_i = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, dz1);
        chk("multu_max_hi", 64'(hi_o), 64'hFFFF_FFFE);
        chk("multu_max_lo", 64'(lo_o), 64'h0000_0001);

        do_op(2'b01, 32'd100, 32'd7, 1'b0, lat, dz1);
        chk("divu_lo", 64'(lo_o), 64'd14);
        chk("divu_hi", 64'(hi_o), 64'd2);
        chk("divu_dz", 64'(div_zero_o), 64'd0);

        do_op(2'b01, 32'h1234, 32'd0, 1'b0, lat, dz1);
        chk("div0_hi", 64'(hi_o), 64'h1234);
        chk("div0_lo", 64'(lo_o), 64'hFFFF_FFFF);
        chk("div0_dz", 64'(div_zero_o), 64'd1);
        do_op(2'b00, 32'd6, 32'd7, 1'b0, lat, dz1);
        chk("dz_cleared_on_start", 64'(dz1), 64'd0);
        chk("mul_small_lo", 64'(lo_o), 64'd42);

`ifdef MULDIV_SIGNED_EN
        do_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, dz1);
        chk("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo_o), 64'hFFFF_FFF1);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, dz1);
        chk("div_s_lo", 64'(lo_o), 64'hFFFF_FFFD);
        chk("div_s_hi", 64'(hi_o), 64'hFFFF_FFFF);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, dz1);
        chk("div_ovf_lo", 64'(lo_o), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi_o), 64'd0);
`else
        do_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, lat, dz1);
        chk("op10_hi", 64'(hi_o), 64'h0000_0004);
        chk("op10_lo", 64'(lo_o), 64'hFFFF_FFF1);
`endif

        do_op(2'b00, 32'd1000, 32'd1000, 1'b1, lat, dz1);
        chk("pulse_hi", 64'(hi_o), 64'd0);
        chk("pulse_lo", 64'(lo_o), 64'd1000000);
        repeat (40) @(negedge clk_i);
        chk("pulse_no_second_busy", 64'(busy_o), 64'd0);

        // Reset mid-multiply, asynchronously between edges.
        @(negedge clk_i);
        start_i = 1'b1;
        op_i    = 2'b00;
        a_i     = 32'hDEAD_BEEF;
        b_i     = 32'h1234_5678;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk("arst_hilo", {hi_o, lo_o}, 64'd0);
        chk("arst_dz",   64'(div_zero_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        do_op(2'b01, 32'd9, 32'd3, 1'b0, lat, dz1);
        chk("post_rst_lo", 64'(lo_o), 64'd3);
        chk("post_rst_hi", 64'(hi_o), 64'd0);

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            do_op(rop, ra, rb, 1'b0, lat, dz1);
        end

        repeat (3) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
